// File: rtl/dmem_miss_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_miss_ctrl
//    M-stage data-memory miss/store sequencer for the dual-issue pipeline.
//    Lane-1/lane-2 read misses are refilled block-wise from main memory and
//    lane-1/lane-2 stores go out as single-beat write-through writes. Only
//    one memory transaction is in flight at a time; lane 1 always wins, and
//    a lane-2 request arriving alongside lane 1 is parked and started right
//    after lane 1's DONE cycle.
//
// Ports
//    clk, rst                     pipeline clock, synchronous active-high reset
//    MemtoRegM1/2, MemWriteM1/2   load / store present in M stage per lane
//    hit1, hit2                   cache tag hit for the lane's load
//    addr1/2, wdata1/2            M-stage byte address and store data
//    stall_m                      M stage held this cycle
//    mem_ack, mem_rdata           memory beat accepted / returned data
//    mem_req, mem_we, mem_addr,   memory request (held until final ack),
//    mem_wdata                    direction, word address, store data
//    fill_we, fill_addr,          cache-array refill write strobe, word
//    fill_data                    address and data
//    readmiss1/2, writemiss1/2    level flags while a lane's op is active
//    ReadReady1/2, WriteReady1/2  one-cycle completion pulses
//    busy                         sequencer not idle
//    All outputs are registered.
// -----------------------------------------------------------------------------
module dmem_miss_ctrl #(
   parameter int BLOCK_WORDS = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemtoRegM1,
   input  logic              MemtoRegM2,
   input  logic              MemWriteM1,
   input  logic              MemWriteM2,
   input  logic              hit1,
   input  logic              hit2,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [DATA_W-1:0] wdata2,
   input  logic              stall_m,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              fill_we,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0] fill_data,
   output logic              readmiss1,
   output logic              readmiss2,
   output logic              writemiss1,
   output logic              writemiss2,
   output logic              ReadReady1,
   output logic              ReadReady2,
   output logic              WriteReady1,
   output logic              WriteReady2,
   output logic              busy
);

   localparam int BW_W  = $clog2(BLOCK_WORDS);
   localparam int OFF_W = BW_W + 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [BW_W-1:0] LAST_BEAT = BW_W'(BLOCK_WORDS - 1);
   localparam logic [BW_W-1:0] BEAT_ONE  = BW_W'(1);

   logic [1:0]        state_r;
   logic [BW_W-1:0]   beat_r;
   logic              served1_r;
   logic              served2_r;
   logic              pend2_r;
   logic              pend_we_r;
   logic [ADDR_W-1:0] pend_addr_r;
   logic [DATA_W-1:0] pend_wdata_r;
   logic              cur_lane_r;   // 0 = lane 1, 1 = lane 2
   logic [ADDR_W-1:0] cur_addr_r;

   logic              rd1_s;
   logic              rd2_s;
   logic              wr1_s;
   logic              wr2_s;
   logic              go1_s;
   logic              go2_s;
   logic              start_s;
   logic              start_lane_s;
   logic              start_we_s;
   logic [ADDR_W-1:0] start_addr_s;
   logic [DATA_W-1:0] start_wdata_s;

   // Word address of a refill beat: block base of a, beat index in the
   // word-offset field, byte offset zero.
   function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [BW_W-1:0]   b);
      logic [ADDR_W-1:0] r;
      r            = a;
      r[OFF_W-1:2] = b;
      r[1:0]       = 2'b00;
      return r;
   endfunction

   // A lane already served in this M-stage occupancy must not re-request.
   assign rd1_s = MemtoRegM1 & ~hit1 & ~served1_r;
   assign rd2_s = MemtoRegM2 & ~hit2 & ~served2_r;
   assign wr1_s = MemWriteM1 & ~served1_r;
   assign wr2_s = MemWriteM2 & ~served2_r;
   assign go1_s = rd1_s | wr1_s;
   assign go2_s = rd2_s | wr2_s;

   // Select the operation launched this cycle: a fresh pick from IDLE or the
   // parked lane-2 op straight out of DONE. Write wins if a lane flags both.
   always_comb begin
      start_s       = 1'b0;
      start_lane_s  = 1'b0;
      start_we_s    = 1'b0;
      start_addr_s  = {ADDR_W{1'b0}};
      start_wdata_s = {DATA_W{1'b0}};
      if ((state_r == ST_IDLE) && (go1_s || go2_s)) begin
         start_s = 1'b1;
         if (go1_s) begin
            start_lane_s  = 1'b0;
            start_we_s    = wr1_s;
            start_addr_s  = addr1;
            start_wdata_s = wdata1;
         end else begin
            start_lane_s  = 1'b1;
            start_we_s    = wr2_s;
            start_addr_s  = addr2;
            start_wdata_s = wdata2;
         end
      end else if ((state_r == ST_DONE) && pend2_r) begin
         start_s       = 1'b1;
         start_lane_s  = 1'b1;
         start_we_s    = pend_we_r;
         start_addr_s  = pend_addr_r;
         start_wdata_s = pend_wdata_r;
      end else begin
         start_s = 1'b0;
      end
   end

   // Sequencer state, served/pending bookkeeping and every registered output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         beat_r       <= {BW_W{1'b0}};
         served1_r    <= 1'b0;
         served2_r    <= 1'b0;
         pend2_r      <= 1'b0;
         pend_we_r    <= 1'b0;
         pend_addr_r  <= {ADDR_W{1'b0}};
         pend_wdata_r <= {DATA_W{1'b0}};
         cur_lane_r   <= 1'b0;
         cur_addr_r   <= {ADDR_W{1'b0}};
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= {ADDR_W{1'b0}};
         mem_wdata    <= {DATA_W{1'b0}};
         fill_we      <= 1'b0;
         fill_addr    <= {ADDR_W{1'b0}};
         fill_data    <= {DATA_W{1'b0}};
         readmiss1    <= 1'b0;
         readmiss2    <= 1'b0;
         writemiss1   <= 1'b0;
         writemiss2   <= 1'b0;
         ReadReady1   <= 1'b0;
         ReadReady2   <= 1'b0;
         WriteReady1  <= 1'b0;
         WriteReady2  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         fill_we     <= 1'b0;
         ReadReady1  <= 1'b0;
         ReadReady2  <= 1'b0;
         WriteReady1 <= 1'b0;
         WriteReady2 <= 1'b0;

         // An advancing M stage forgets what was served; that wins over DONE.
         if (!stall_m) begin
            served1_r <= 1'b0;
            served2_r <= 1'b0;
         end else if (state_r == ST_DONE) begin
            if (cur_lane_r) begin
               served2_r <= 1'b1;
            end else begin
               served1_r <= 1'b1;
            end
         end

         case (state_r)
            ST_IDLE: begin
               // Park lane 2 when it must wait behind lane 1.
               if (go1_s && go2_s) begin
                  pend2_r      <= 1'b1;
                  pend_we_r    <= wr2_s;
                  pend_addr_r  <= addr2;
                  pend_wdata_r <= wdata2;
               end
            end
            ST_READ: begin
               if (mem_ack) begin
                  fill_we   <= 1'b1;
                  fill_addr <= mem_addr;
                  fill_data <= mem_rdata;
                  if (beat_r == LAST_BEAT) begin
                     beat_r    <= {BW_W{1'b0}};
                     mem_req   <= 1'b0;
                     readmiss1 <= 1'b0;
                     readmiss2 <= 1'b0;
                     state_r   <= ST_DONE;
                     if (cur_lane_r) begin
                        ReadReady2 <= 1'b1;
                     end else begin
                        ReadReady1 <= 1'b1;
                     end
                  end else begin
                     beat_r   <= beat_r + BEAT_ONE;
                     mem_addr <= beat_addr(cur_addr_r, beat_r + BEAT_ONE);
                  end
               end
            end
            ST_WRITE: begin
               if (mem_ack) begin
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  writemiss1 <= 1'b0;
                  writemiss2 <= 1'b0;
                  state_r    <= ST_DONE;
                  if (cur_lane_r) begin
                     WriteReady2 <= 1'b1;
                  end else begin
                     WriteReady1 <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               pend2_r <= 1'b0;
               if (!start_s) begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               busy    <= 1'b0;
            end
         endcase

         // Launch a new memory op (from IDLE or back-to-back from DONE).
         if (start_s) begin
            cur_lane_r <= start_lane_s;
            cur_addr_r <= start_addr_s;
            beat_r     <= {BW_W{1'b0}};
            mem_req    <= 1'b1;
            mem_we     <= start_we_s;
            busy       <= 1'b1;
            if (start_we_s) begin
               state_r   <= ST_WRITE;
               mem_addr  <= {start_addr_s[ADDR_W-1:2], 2'b00};
               mem_wdata <= start_wdata_s;
               if (start_lane_s) begin
                  writemiss2 <= 1'b1;
               end else begin
                  writemiss1 <= 1'b1;
               end
            end else begin
               state_r  <= ST_READ;
               mem_addr <= beat_addr(start_addr_s, {BW_W{1'b0}});
               if (start_lane_s) begin
                  readmiss2 <= 1'b1;
               end else begin
                  readmiss1 <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/dmem_miss_ctrl.md
Name: dmem_miss_ctrl

Overview:
- Data-memory miss/store sequencer in the M stage of the dual-issue pipeline.
- Services lane-1 and lane-2 read misses with block refills from main memory, and lane-1/lane-2 stores as write-through single-beat writes.
- Produces the level miss flags and one-cycle ready pulses that the hazard unit uses to raise and release the data-memory stall.
- One memory transaction is in flight at a time; lane 1 always has priority.

Parameters:
- BLOCK_WORDS, 4, words per cache block; must be a power of 2 and at least 2.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- MemtoRegM1, MemtoRegM2  in  1  load in M stage, lane 1 / lane 2.
- MemWriteM1, MemWriteM2  in  1  store in M stage, lane 1 / lane 2.
- hit1, hit2  in  1  cache tag hit for the lane's load address.
- addr1, addr2  in  ADDR_W  M-stage byte address.
- wdata1, wdata2  in  DATA_W  store data.
- stall_m  in  1  M stage held this cycle (StallM1|StallM2).
- mem_ack  in  1  memory beat accepted/returned.
- mem_rdata  in  DATA_W  read beat data.
- mem_req  out  1  memory request, held until the final ack.
- mem_we  out  1  1 = write beat.
- mem_addr  out  ADDR_W  word-aligned beat address.
- mem_wdata  out  DATA_W  store data.
- fill_we  out  1  cache-array write strobe.
- fill_addr  out  ADDR_W  refill word address.
- fill_data  out  DATA_W  refill word.
- readmiss1, readmiss2  out  1  level, read refill active for that lane.
- writemiss1, writemiss2  out  1  level, store active for that lane.
- ReadReady1, ReadReady2, WriteReady1, WriteReady2  out  1  one-cycle completion pulses.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous): state=IDLE, beat=0, served1=served2=0, pend2=0, and every output 0.
- All outputs are registered.
- Request qualification:
  - rd_n = MemtoRegMn & ~hitn & ~servedn.
  - wr_n = MemWriteMn & ~servedn.
  - If both rd_n and wr_n are set (illegal), the write is serviced.
- Served flags:
  - servedn is set on that lane's DONE.
  - Both served flags clear on any edge where stall_m=0 (M stage advanced).
  - Clearing takes priority over setting in the same cycle.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Lane 1 is picked if it is qualified; otherwise lane 2.
  - When lane 1 is picked and lane 2 is also qualified, set pend2=1 and capture addr2/wdata2/op2.
  - Picked lane's address and data are captured.
  - Entering READ: beat=0, mem_req=1, mem_we=0, readmissN=1.
  - Entering WRITE: mem_req=1, mem_we=1, writemissN=1.
  - mem_ack in IDLE is ignored.
- READ:
  - mem_addr = {addr[ADDR_W-1 : 2+log2(BLOCK_WORDS)], beat, 2'b00}.
  - Each mem_ack pulses fill_we with fill_addr=mem_addr and fill_data=mem_rdata, then increments beat.
  - On the ack with beat = BLOCK_WORDS-1: drop mem_req and readmissN, go to DONE.
  - Beat counter wraps to 0 on exit.
- WRITE:
  - mem_addr = addr with bits [1:0] forced to 0; mem_wdata = captured data.
  - On mem_ack: drop mem_req, mem_we and writemissN, go to DONE.
- DONE (exactly one cycle):
  - Pulse ReadReadyN or WriteReadyN for the served lane and set servedN.
  - If pend2=1: clear pend2 and start the captured lane-2 op directly (READ or WRITE) on the next edge, with no IDLE cycle.
  - Otherwise return to IDLE.
- Latency:
  - Read miss = 1 + (cycles to BLOCK_WORDS acks) + 1 DONE.
  - Store = 1 + (cycles to ack) + 1 DONE.
  - With a zero-wait memory (ack on every cycle mem_req is high): read = BLOCK_WORDS+2 cycles request-to-ReadReady; store = 3 cycles.
- Ack beyond the last beat: impossible, since mem_req is already low; any such ack is ignored.
- Reset mid-operation: immediate IDLE, mem_req=0, no ready pulse, pend2 discarded, partial fill abandoned (fill_we=0).

Test Plan:
- Lane-1 load miss, addr1=0x0000_0048, BLOCK_WORDS=4, ack every cycle -> mem_addr 0x40, 0x44, 0x48, 0x4C; four fill_we pulses; readmiss1 high for 4 cycles; ReadReady1 pulses once, 6 cycles after the request.
- Lane-2 store, addr2=0x103, wdata2=0xDEADBEEF, ack delayed 3 cycles -> mem_we=1, mem_addr=0x100, writemiss2 high until the ack, one WriteReady2 pulse, no fill_we.
- Simultaneous lane-1 store and lane-2 load miss -> lane 1 is written first, WriteReady1 is followed directly by the READ for lane 2, then ReadReady2; no IDLE cycle between them.
- Store held with stall_m=1 after WriteReady1 -> no second memory write; after one stall_m=0 edge, a new MemWriteM1 starts a new write.
- rst asserted after 2 of 4 refill acks -> next cycle mem_req=0, readmiss1=0, busy=0, no ReadReady1; a later miss restarts at beat 0.
- Load with hit1=1 -> no mem_req, and all miss and ready outputs stay 0.
